// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment capture block: active-low segment
// patterns (bit 0 = a .. bit 6 = g), FSM states and display bus types.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int DISP_W     = NUM_DIGITS * SEG_W;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

  typedef logic [6:0] seg_bus_t [7:0];

endpackage

// File: rtl/seven_seg_digit_decode.sv
// Combinational decode of one active-low seven-segment pattern back to a hex
// nibble; all-off reports blank, anything unrecognised reports error.
module seven_seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       error
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    error  = 1'b0;
    case (seg_n)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   error  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples eight active-low seven-segment buses, waits for a steady display and
// publishes the decoded snapshot over valid/ready. SEVEN_SEG_CAPTURE_ERR_EN drops illegal snapshots.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic        clock_50,
  input  logic        resetn,
  input  logic        enable,
  input  logic [6:0]  seven_seg_n [7:0],
  output logic        capture_valid,
  input  logic        capture_ready,
  output logic [31:0] capture_value,
  output logic [7:0]  capture_blank,
  output logic [7:0]  capture_error,
  output logic [15:0] capture_count
);

  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

  logic [DISP_W-1:0] seg_in;
  logic [DISP_W-1:0] sync1_q, sync1_d;
  logic [DISP_W-1:0] cur_q, cur_d;
  logic [DISP_W-1:0] prev_q, prev_d;
  logic [DISP_W-1:0] hold_raw_q, hold_raw_d;
  logic [DISP_W-1:0] last_pub_q, last_pub_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              stable_q, stable_d;
  logic              has_pub_q, has_pub_d;
  state_t            state_q, state_d;
  logic [31:0]       value_q, value_d;
  logic [7:0]        blank_q, blank_d;
  logic [7:0]        error_q, error_d;
  logic [15:0]       count_q, count_d;

  logic [31:0]       dec_value;
  logic [7:0]        dec_blank;
  logic [7:0]        dec_error;
  logic [7:0]        err_pub;
  logic              same;
  logic              stable;
  logic              new_pattern;
  logic              err_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign seg_in[gi*SEG_W +: SEG_W] = seven_seg_n[gi];

      seven_seg_digit_decode u_dec (
        .seg_n  (cur_q[gi*SEG_W +: SEG_W]),
        .nibble (dec_value[gi*4 +: 4]),
        .blank  (dec_blank[gi]),
        .error  (dec_error[gi])
      );
    end
  endgenerate

`ifdef SEVEN_SEG_CAPTURE_ERR_EN
  assign err_ok  = (dec_error == 8'h00);
  assign err_pub = dec_error;
`else
  logic unused_dec_error;
  assign unused_dec_error = ^dec_error;
  assign err_ok  = 1'b1;
  assign err_pub = 8'h00;
`endif

  assign same        = (cur_q == prev_q);
  // stable_q lags the counter by one cycle; re-checking `same` keeps a fresh change from slipping through
  assign stable      = stable_q && same;
  assign new_pattern = !has_pub_q || (cur_q != last_pub_q);

  always_comb begin
    sync1_d = seg_in;
    cur_d   = sync1_q;
    prev_d  = cur_q;

    if (!enable || !same) begin
      cnt_d = 16'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    stable_d = enable && same && (cnt_q == CNT_MAX);
  end

  always_comb begin
    state_d    = state_q;
    has_pub_d  = has_pub_q;
    last_pub_d = last_pub_q;
    hold_raw_d = hold_raw_q;
    value_d    = value_q;
    blank_d    = blank_q;
    error_d    = error_q;
    count_d    = count_q;

    if (!enable) begin
      state_d   = S_IDLE;
      has_pub_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_TRACK;
        S_TRACK: begin
          if (stable && new_pattern && err_ok) begin
            state_d    = S_HOLD;
            hold_raw_d = cur_q;
            value_d    = dec_value;
            blank_d    = dec_blank;
            error_d    = err_pub;
          end
        end
        S_HOLD: begin
          if (capture_ready) begin
            state_d    = S_TRACK;
            has_pub_d  = 1'b1;
            last_pub_d = hold_raw_q;
            if (count_q != 16'hFFFF) begin
              count_d = count_q + 16'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= '0;
      cur_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= 16'd0;
      stable_q   <= 1'b0;
      has_pub_q  <= 1'b0;
      last_pub_q <= '0;
      hold_raw_q <= '0;
      state_q    <= S_IDLE;
      value_q    <= 32'h0;
      blank_q    <= 8'h00;
      error_q    <= 8'h00;
      count_q    <= 16'd0;
    end else begin
      sync1_q    <= sync1_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      has_pub_q  <= has_pub_d;
      last_pub_q <= last_pub_d;
      hold_raw_q <= hold_raw_d;
      state_q    <= state_d;
      value_q    <= value_d;
      blank_q    <= blank_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign capture_valid = (state_q == S_HOLD);
  assign capture_value = value_q;
  assign capture_blank = blank_q;
  assign capture_error = error_q;
  assign capture_count = count_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Randomised and directed bench for seven_seg_capture against a window-rule model
// of the display: publish when the last S+2 synchronised samples agree and enable has been held.
module tb_seven_seg_capture;

  localparam int S = 4;
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic        clock_50 = 1'b0;
  logic        resetn;
  logic        enable;
  logic        capture_ready;
  logic [6:0]  seg_drv [7:0];
  logic        capture_valid;
  logic [31:0] capture_value;
  logic [7:0]  capture_blank;
  logic [7:0]  capture_error;
  logic [15:0] capture_count;

  always #5 clock_50 = ~clock_50;

  seven_seg_capture #(.STABLE_CYCLES(S)) dut (
    .clock_50      (clock_50),
    .resetn        (resetn),
    .enable        (enable),
    .seven_seg_n   (seg_drv),
    .capture_valid (capture_valid),
    .capture_ready (capture_ready),
    .capture_value (capture_value),
    .capture_blank (capture_blank),
    .capture_error (capture_error),
    .capture_count (capture_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [55:0] hist [$];
  int          en_run;
  bit          m_hold;
  bit          m_has_pub;
  logic [55:0] m_held_raw;
  logic [55:0] m_last_pub;
  logic [31:0] m_value;
  logic [7:0]  m_blank;
  logic [7:0]  m_error;
  logic [15:0] m_count;
  logic [31:0] last_seen = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void decode_disp(input logic [55:0] d, output logic [31:0] v,
                                      output logic [7:0] b, output logic [7:0] e);
    v = '0;
    b = '0;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      logic [6:0] p;
      bit hit;
      p = d[i*7 +: 7];
      hit = 1'b0;
      for (int n = 0; n < 16; n++) begin
        if (SEG_TAB[n] == p) begin
          v[i*4 +: 4] = 4'(n);
          hit = 1'b1;
        end
      end
      if (!hit) begin
        if (p == 7'h7F) b[i] = 1'b1;
        else            e[i] = 1'b1;
      end
    end
  endfunction

  function automatic logic [55:0] pack_disp();
    logic [55:0] d;
    for (int i = 0; i < 8; i++) d[i*7 +: 7] = seg_drv[i];
    return d;
  endfunction

  task automatic set_hex(input logic [31:0] h);
    for (int i = 0; i < 8; i++) seg_drv[i] = SEG_TAB[h[i*4 +: 4]];
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + 4; i++) hist.push_back(56'h0);
    en_run     = 0;
    m_hold     = 1'b0;
    m_has_pub  = 1'b0;
    m_held_raw = '0;
    m_last_pub = '0;
    m_value    = '0;
    m_blank    = '0;
    m_error    = '0;
    m_count    = '0;
  endtask

  // called just after each rising edge, with the inputs that edge sampled
  task automatic model_edge();
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  e;
    bit          ok;
    if (!resetn) begin
      model_reset();
      return;
    end
    hist.push_front(pack_disp());
    while (hist.size() > S + 4) void'(hist.pop_back());
    en_run = enable ? ((en_run < 1000000) ? en_run + 1 : en_run) : 0;
    if (!enable) begin
      m_hold    = 1'b0;
      m_has_pub = 1'b0;
    end else if (m_hold) begin
      if (capture_ready) begin
        m_hold     = 1'b0;
        m_has_pub  = 1'b1;
        m_last_pub = m_held_raw;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        $display("publish #%0d value=%h blank=%h error=%h", m_count, m_value, m_blank, m_error);
      end
    end else begin
      ok = (en_run >= S + 1);
      for (int i = 3; i <= S + 3; i++) if (hist[i] != hist[2]) ok = 1'b0;
      decode_disp(hist[2], v, b, e);
      if (ok && (!m_has_pub || hist[2] != m_last_pub) && !(ERR_EN && e != 8'h00)) begin
        m_hold     = 1'b1;
        m_held_raw = hist[2];
        m_value    = v;
        m_blank    = b;
        m_error    = ERR_EN ? e : 8'h00;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", capture_valid, m_hold);
    check_eq("count", capture_count, m_count);
    check_eq("value", capture_value, m_value);
    check_eq("blank", capture_blank, m_blank);
    check_eq("error", capture_error, m_error);
    if (capture_valid) last_seen = capture_value;
  endtask

  task automatic tick();
    @(posedge clock_50);
    model_edge();
    @(negedge clock_50);
    check_outputs();
  endtask

  // reset asserted between edges; outputs must clear without a clock
  task automatic async_reset();
    #2 resetn = 1'b0;
    #1 model_reset();
    check_outputs();
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    capture_ready = 1'b0;
    set_hex(32'h0);
    model_reset();
    repeat (2) tick();
    resetn = 1'b1;

    // basic capture with a one-cycle glitch inside the window
    enable = 1'b1;
    capture_ready = 1'b1;
    set_hex(32'h12345678);
    repeat (3) tick();
    seg_drv[0] = SEG_TAB[9];
    tick();
    seg_drv[0] = SEG_TAB[8];
    repeat (20) tick();
    check_eq("basic_value", last_seen, 32'h12345678);
    check_eq("basic_count", capture_count, 32'd1);

    // back-pressure from a fresh reset, then back-to-back publish
    async_reset();
    capture_ready = 1'b0;
    repeat (12) tick();
    check_eq("bp_valid", capture_valid, 1'b1);
    set_hex(32'hABCDEF01);
    repeat (10) tick();
    check_eq("bp_hold_value", capture_value, 32'h12345678);
    capture_ready = 1'b1;
    tick();
    check_eq("b2b_gap", capture_valid, 1'b0);
    tick();
    check_eq("b2b_rise", capture_valid, 1'b1);
    check_eq("b2b_value", capture_value, 32'hABCDEF01);
    repeat (3) tick();
    check_eq("bp_count", capture_count, 32'd2);

    // blank digit 7 and illegal digit 6
    set_hex(32'h00345678);
    seg_drv[7] = 7'h7F;
    seg_drv[6] = 7'b1010101;
    repeat (20) tick();
`ifdef SEVEN_SEG_CAPTURE_ERR_EN
    check_eq("illegal_dropped", capture_count, 32'd2);
`else
    check_eq("blank_hi_byte", {24'h0, last_seen[31:24]}, 32'h0);
    check_eq("blank_mask", capture_blank, 8'h80);
    check_eq("blank_count", capture_count, 32'd3);
`endif

    // abort by dropping enable during HOLD, then republish
    capture_ready = 1'b0;
    set_hex(32'hCAFE0123);
    repeat (12) tick();
    check_eq("abort_valid", capture_valid, 1'b1);
    enable = 1'b0;
    tick();
    check_eq("abort_drop", capture_valid, 1'b0);
    check_eq("abort_count", capture_count, ERR_EN ? 32'd2 : 32'd3);
    enable = 1'b1;
    capture_ready = 1'b1;
    repeat (15) tick();
    check_eq("abort_republish", last_seen, 32'hCAFE0123);
    check_eq("abort_count2", capture_count, ERR_EN ? 32'd3 : 32'd4);

    // mid-window reset: nothing published before a full window after release
    set_hex(32'h13579BDF);
    repeat (4) tick();
    async_reset();
    for (int i = 0; i < S + 2; i++) begin
      tick();
      check_eq("rst_no_early", capture_valid, 1'b0);
    end
    repeat (10) tick();
    check_eq("rst_republish", last_seen, 32'h13579BDF);

    // randomised traffic
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      r = $urandom_range(99);
      if (r >= 10) begin
        set_hex($urandom);
        if (r >= 88) seg_drv[$urandom_range(7)] = (r >= 94) ? 7'h7F : 7'($urandom);
      end
      for (int h = 0; h < $urandom_range(14, 1); h++) begin
        capture_ready = ($urandom_range(9) < 7);
        enable = ($urandom_range(49) != 0);
        if ($urandom_range(19) == 0) begin
          int d;
          logic [6:0] saved;
          d = $urandom_range(7);
          saved = seg_drv[d];
          seg_drv[d] = saved ^ 7'(1 << $urandom_range(6));
          tick();
          seg_drv[d] = saved;
        end else begin
          tick();
        end
      end
      if ($urandom_range(99) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
